// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants, FSM state type and packed-word field offsets
package fpu_pkg;

    localparam int FP_EXP_BITS  = 8;
    localparam int FP_MANT_BITS = 23;

    localparam int EXP_MAX = (1 << FP_EXP_BITS) - 1;
    localparam int BIAS    = (1 << (FP_EXP_BITS - 1)) - 1;

    // Bit offsets inside the packed {sign, exp, fraction} word
    localparam int FRAC_LSB = 0;
    localparam int EXP_LSB  = FP_MANT_BITS;
    localparam int SIGN_POS = FP_EXP_BITS + FP_MANT_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fp_state_e;

endpackage

// File: rtl/fp_rne_round.sv
// rtl/fp_rne_round.sv - combinational round-to-nearest-even on a hidden+fraction mantissa
module fp_rne_round
    import fpu_pkg::*;
#(
    parameter int MANT_BITS = FP_MANT_BITS
) (
    input  logic [MANT_BITS:0] mant,
    input  logic               g,
    input  logic               r,
    input  logic               s,
    output logic [MANT_BITS:0] mant_rnd,
    output logic               carry_out
);

    logic inc;

    // Round up above the halfway point, or exactly at it when the lsb is odd
    assign inc = g & (r | s | mant[0]);

    assign {carry_out, mant_rnd} = {1'b0, mant} + (MANT_BITS + 2)'(inc);

endmodule

// File: rtl/fp_normalize_pack.sv
// rtl/fp_normalize_pack.sv - iterative normalise, RNE round and IEEE-754 pack for the add/sub path
module fp_normalize_pack
    import fpu_pkg::*;
#(
    parameter int EXP_BITS  = FP_EXP_BITS,
    parameter int MANT_BITS = FP_MANT_BITS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            sign_r,
    input  logic [EXP_BITS-1:0]             exp_in,
    input  logic [MANT_BITS+1:0]            mant_in,
    input  logic [2:0]                      grs_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXP_BITS+MANT_BITS:0]     result,
    output logic                            flag_overflow,
    output logic                            flag_underflow,
    output logic                            flag_zero
);

    localparam int MW = MANT_BITS + 2;
    localparam int EW = EXP_BITS + 1;
    localparam int RW = 1 + EXP_BITS + MANT_BITS;

    localparam logic [EW-1:0] EXP_ONE = EW'(1);
    localparam logic [EW-1:0] EXP_ALL = {1'b0, {EXP_BITS{1'b1}}};

    fp_state_e state, state_nxt;

    logic            sign_q;
    logic [EW-1:0]   exp_q;
    logic [MW-1:0]   mant_q;
    logic            g_q, r_q, s_q;
    logic            zero_q, uf_q;
    logic [RW-1:0]   result_q;
    logic            ovf_flag_q, uf_flag_q, zero_flag_q;

    logic carry_bit, hidden_bit, is_zero, exp_low, norm_done;

    assign carry_bit  = mant_q[MW-1];
    assign hidden_bit = mant_q[MANT_BITS];
    assign is_zero    = (mant_q == '0) && ({g_q, r_q, s_q} == 3'b000);
    assign exp_low    = (exp_q <= EXP_ONE);
    assign norm_done  = carry_bit | is_zero | hidden_bit | exp_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = NORM;
            NORM:    if (norm_done) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic [MANT_BITS:0]   mant_rnd;
    logic                 rnd_carry;
    logic [EW-1:0]        exp_rnd;
    logic [MANT_BITS-1:0] frac_rnd;
    logic                 flush, ovf, uf_out;
    logic [RW-1:0]        pack_word;

    fp_rne_round #(
        .MANT_BITS (MANT_BITS)
    ) u_round (
        .mant      (mant_q[MANT_BITS:0]),
        .g         (g_q),
        .r         (r_q),
        .s         (s_q),
        .mant_rnd  (mant_rnd),
        .carry_out (rnd_carry)
    );

    // A rounding carry leaves 1.000..0, so the renormalised fraction is the upper slice
    assign exp_rnd  = exp_q + EW'(rnd_carry);
    assign frac_rnd = rnd_carry ? mant_rnd[MANT_BITS:1] : mant_rnd[MANT_BITS-1:0];

    // A zero biased exponent would be a denormal, which this path never emits
    assign flush  = zero_q | uf_q | (exp_rnd == '0);
    assign uf_out = uf_q | ((exp_rnd == '0) & ~zero_q);
    assign ovf    = ~flush & (exp_rnd >= EXP_ALL);

    always_comb begin
        pack_word = '0;
        if (flush) begin
            pack_word = {sign_q, {EXP_BITS{1'b0}}, {MANT_BITS{1'b0}}};
        end else if (ovf) begin
            pack_word = {sign_q, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
        end else begin
            pack_word = {sign_q, exp_rnd[EXP_BITS-1:0], frac_rnd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            g_q         <= 1'b0;
            r_q         <= 1'b0;
            s_q         <= 1'b0;
            zero_q      <= 1'b0;
            uf_q        <= 1'b0;
            result_q    <= '0;
            ovf_flag_q  <= 1'b0;
            uf_flag_q   <= 1'b0;
            zero_flag_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q            <= sign_r;
                        exp_q             <= {1'b0, exp_in};
                        mant_q            <= mant_in;
                        {g_q, r_q, s_q}   <= grs_in;
                        zero_q            <= 1'b0;
                        uf_q              <= 1'b0;
                    end
                end
                NORM: begin
                    if (carry_bit) begin
                        mant_q <= mant_q >> 1;
                        g_q    <= mant_q[0];
                        r_q    <= g_q;
                        s_q    <= r_q | s_q;
                        exp_q  <= exp_q + EXP_ONE;
                    end else if (is_zero) begin
                        zero_q <= 1'b1;
                    end else if (hidden_bit) begin
                        zero_q <= 1'b0;
                    end else if (exp_low) begin
                        uf_q   <= 1'b1;
                    end else begin
                        // Guard bit refills the lsb; sticky stays as collected
                        mant_q <= {mant_q[MW-2:0], g_q};
                        g_q    <= r_q;
                        r_q    <= 1'b0;
                        exp_q  <= exp_q - EXP_ONE;
                    end
                end
                ROUND: begin
                    result_q    <= pack_word;
                    ovf_flag_q  <= ovf;
                    uf_flag_q   <= uf_out;
                    zero_flag_q <= flush;
                end
                default: begin
                    result_q <= result_q;
                end
            endcase
        end
    end

    assign in_ready       = (state == IDLE);
    assign out_valid      = (state == DONE);
    assign result         = result_q;
    assign flag_overflow  = ovf_flag_q;
    assign flag_underflow = uf_flag_q;
    assign flag_zero      = zero_flag_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// tb/tb_fp_normalize_pack.sv - directed vector bench for fp_normalize_pack
module tb_fp_normalize_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_r = 1'b0;
    logic [7:0]  exp_in = '0;
    logic [24:0] mant_in = '0;
    logic [2:0]  grs_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        flag_overflow, flag_underflow, flag_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_normalize_pack #(
        .EXP_BITS  (8),
        .MANT_BITS (23)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sign_r         (sign_r),
        .exp_in         (exp_in),
        .mant_in        (mant_in),
        .grs_in         (grs_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow),
        .flag_zero      (flag_zero)
    );

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic [2:0]  grs;
        logic [31:0] res;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic apply(input vec_t v, output int lat, output bit seen);
        @(negedge clk);
        sign_r   = v.sign;
        exp_in   = v.exp;
        mant_in  = v.mant;
        grs_in   = v.grs;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) seen = 1'b1;
        end
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({name, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({name, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int  lat;
        bit  seen;
        bit  stray;
        string nm;

        // {sign, exp, mant, grs, result, {ovf,uf,zero}, latency}
        vecs[0]  = '{1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 3'b000, 2};
        vecs[1]  = '{1'b0, 8'd127, 25'h0400000, 3'b000, 32'h3F000000, 3'b000, 3};
        vecs[2]  = '{1'b0, 8'd127, 25'h0000000, 3'b000, 32'h00000000, 3'b001, 2};
        vecs[3]  = '{1'b1, 8'd127, 25'h0000000, 3'b000, 32'h80000000, 3'b001, 2};
        vecs[4]  = '{1'b0, 8'd254, 25'h1000000, 3'b000, 32'h7F800000, 3'b100, 2};
        vecs[5]  = '{1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 32'h40000000, 3'b000, 2};
        vecs[6]  = '{1'b0, 8'd1,   25'h0000001, 3'b000, 32'h00000000, 3'b011, 2};
        vecs[7]  = '{1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 3'b000, 2};
        vecs[8]  = '{1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 3'b000, 2};
        vecs[9]  = '{1'b0, 8'd127, 25'h1000003, 3'b000, 32'h40000002, 3'b000, 2};
        vecs[10] = '{1'b0, 8'd130, 25'h0200000, 3'b000, 32'h40000000, 3'b000, 4};
        vecs[11] = '{1'b0, 8'd127, 25'h0400000, 3'b100, 32'h3F000001, 3'b000, 3};
        vecs[12] = '{1'b0, 8'd0,   25'h0800000, 3'b000, 32'h00000000, 3'b011, 2};
        vecs[13] = '{1'b0, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 3'b000, 25};
        vecs[14] = '{1'b0, 8'd3,   25'h0100000, 3'b000, 32'h00000000, 3'b011, 4};
        vecs[15] = '{1'b1, 8'd255, 25'h0800000, 3'b000, 32'hFF800000, 3'b100, 2};

        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", 32'({flag_overflow, flag_underflow, flag_zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            nm = $sformatf("v%0d", i);
            check({nm, " in_ready"}, 32'(in_ready), 32'd1);
            apply(vecs[i], lat, seen);
            check({nm, " out_valid seen"}, 32'(seen), 32'd1);
            check({nm, " result"}, result, vecs[i].res);
            check({nm, " flags"}, 32'({flag_overflow, flag_underflow, flag_zero}), 32'(vecs[i].flags));
            check({nm, " latency"}, 32'(lat), 32'(vecs[i].lat));
            release_result(nm);
        end

        // Backpressure: result held, new operands ignored while DONE
        apply(vecs[0], lat, seen);
        check("bp out_valid seen", 32'(seen), 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        exp_in   = 8'd100;
        mant_in  = 25'h0400000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp result c%0d", c), result, 32'h40000000);
            check($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd0);
            check($sformatf("bp out_valid c%0d", c), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        release_result("bp");
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1 if (out_valid) stray = 1'b1;
        end
        check("bp second op ignored", 32'(stray), 32'd0);

        // Asynchronous reset in the middle of a long normalisation
        @(negedge clk);
        sign_r   = 1'b0;
        exp_in   = 8'd140;
        mant_in  = 25'h0000001;
        grs_in   = 3'b000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        check("mid-norm busy", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async rst in_ready", 32'(in_ready), 32'd1);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst result", result, 32'd0);
        check("async rst flags", 32'({flag_overflow, flag_underflow, flag_zero}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1 if (out_valid) stray = 1'b1;
        end
        check("rst no result", 32'(stray), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);

        apply(vecs[1], lat, seen);
        check("post-rst seen", 32'(seen), 32'd1);
        check("post-rst result", result, 32'h3F000000);
        check("post-rst latency", 32'(lat), 32'd3);
        release_result("post-rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
